// File: rtl/ddr_wr_burst_ctrl_if.sv
// rtl/ddr_wr_burst_ctrl_if.sv - FIFO read, DDR write command/data and response signals of the burst controller
interface ddr_wr_burst_ctrl_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 28,
    parameter int LEVEL_WIDTH = 10
);
    logic [LEVEL_WIDTH-1:0] fifo_rd_level;
    logic                   fifo_rd_empty;
    logic                   fifo_rd_en;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [7:0]             cmd_len;
    logic                   wdata_valid;
    logic                   wdata_ready;
    logic [DATA_WIDTH-1:0]  wdata;
    logic                   wdata_last;
    logic                   wresp_valid;

    modport master (
        input  fifo_rd_level, fifo_rd_empty, fifo_rd_data, cmd_ready, wdata_ready, wresp_valid,
        output fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, wdata_last
    );

    modport slave (
        output fifo_rd_level, fifo_rd_empty, fifo_rd_data, cmd_ready, wdata_ready, wresp_valid,
        input  fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, wdata_last
    );
endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// rtl/ddr_wr_burst_ctrl.sv - drains fixed-length FIFO bursts into DDR write commands; DDR_WR_PINGPONG_EN adds a second frame buffer
module ddr_wr_burst_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 28,
    parameter int LEVEL_WIDTH = 10,
    parameter int BURST_LEN   = 64,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_BYTES = 1572864
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    ddr_wr_burst_ctrl_if.master bus,
    output logic                busy,
    output logic                frame_buf_idx
);
`ifdef DDR_WR_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [AW1-1:0]        BSTEP     = AW1'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [AW1-1:0]        FBYTES    = AW1'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BASE0     = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE1     = PINGPONG ? ADDR_WIDTH'(FRAME_BASE + FRAME_BYTES) : BASE0;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]      BURST_CNT = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic                   pending_frame;
    logic [DATA_WIDTH-1:0]  skid [2];
    logic [1:0]             skid_cnt;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic                   rd_inflight;
    logic [CNT_W-1:0]       rd_req;
    logic [CNT_W-1:0]       beat_cnt;

    logic [LEVEL_WIDTH-1:0] level;
    logic                   level_ok;
    logic                   pop;
    logic [1:0]             occupancy;
    logic                   new_idx;
    logic [ADDR_WIDTH-1:0]  cur_base;
    logic [ADDR_WIDTH-1:0]  new_base;
    logic [AW1-1:0]         inc_addr;
    logic                   addr_wrap;

    assign level    = bus.fifo_rd_level;
    assign level_ok = (32'(level) >= BURST_LEN);

    always_comb begin
        new_idx   = frame_buf_idx ^ PINGPONG;
        cur_base  = frame_buf_idx ? BASE1 : BASE0;
        new_base  = new_idx ? BASE1 : BASE0;
        inc_addr  = {1'b0, cur_addr} + BSTEP;
        addr_wrap = (inc_addr >= ({1'b0, cur_base} + FBYTES));
    end

    assign bus.wdata_valid = (skid_cnt != 2'd0);
    assign pop             = bus.wdata_valid & bus.wdata_ready;
    assign bus.wdata       = bus.wdata_valid ? skid[rd_ptr] : '0;
    assign bus.wdata_last  = bus.wdata_valid && (beat_cnt == LAST_BEAT);
    assign bus.cmd_len     = bus.cmd_valid ? 8'(BURST_LEN - 1) : 8'd0;
    assign busy            = (state != IDLE);

    // A slot being popped this cycle counts as free, which keeps one beat per clock.
    assign occupancy      = skid_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    assign bus.fifo_rd_en = (state == DATA) && !bus.fifo_rd_empty &&
                            (occupancy < 2'd2) && (rd_req < BURST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_addr      <= BASE0;
            frame_buf_idx <= 1'b0;
            pending_frame <= 1'b0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_addr  <= '0;
            skid[0]       <= '0;
            skid[1]       <= '0;
            skid_cnt      <= 2'd0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            rd_inflight   <= 1'b0;
            rd_req        <= '0;
            beat_cnt      <= '0;
        end else begin
            rd_inflight <= bus.fifo_rd_en;
            if (rd_inflight) begin
                skid[wr_ptr] <= bus.fifo_rd_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt + 1'b1;
            end
            skid_cnt <= occupancy;
            if (bus.fifo_rd_en) rd_req <= rd_req + 1'b1;
            if (frame_start && (state != IDLE)) pending_frame <= 1'b1;

            case (state)
                IDLE: begin
                    // A frame start wins over a ready level; the burst then starts a cycle later.
                    if (frame_start) begin
                        cur_addr      <= new_base;
                        frame_buf_idx <= new_idx;
                    end else if (level_ok && !pending_frame) begin
                        state         <= CMD;
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_addr  <= cur_addr;
                    end
                end
                CMD: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state         <= DATA;
                        beat_cnt      <= '0;
                        rd_req        <= '0;
                    end
                end
                DATA: begin
                    if (pop && (beat_cnt == LAST_BEAT)) state <= RESP;
                end
                RESP: begin
                    if (bus.wresp_valid) begin
                        state         <= IDLE;
                        pending_frame <= 1'b0;
                        if (pending_frame || frame_start) begin
                            cur_addr      <= new_base;
                            frame_buf_idx <= new_idx;
                        end else if (addr_wrap) begin
                            cur_addr <= cur_base;
                        end else begin
                            cur_addr <= inc_addr[ADDR_WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb/tb_ddr_wr_burst_ctrl.sv - table-driven bench for ddr_wr_burst_ctrl with a four-burst frame
module tb_ddr_wr_burst_ctrl;
    localparam int FB = 2048;
`ifdef DDR_WR_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic busy;
    logic frame_buf_idx;

    ddr_wr_burst_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(28), .LEVEL_WIDTH(10)) bus ();

    ddr_wr_burst_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(28), .LEVEL_WIDTH(10),
        .BURST_LEN(64), .FRAME_BASE(0), .FRAME_BYTES(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .bus(bus), .busy(busy), .frame_buf_idx(frame_buf_idx)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [4096];
    logic [63:0] exp_q [$];
    int wp = 0;
    int rp = 0;
    int pk = 0;

    assign bus.fifo_rd_level = 10'(wp - rp);
    assign bus.fifo_rd_empty = (wp == rp);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wp != rp)) begin
            bus.fifo_rd_data <= mem[rp];
            rp <= rp + 1;
        end
    end

    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #2;
        bus.wdata_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int beats = 0, rd_cnt = 0, data_err = 0, last_err = 0;
    int stall_err = 0, empty_err = 0, cmd_seen = 0, cmd_cycles = 0;
    logic [27:0] cmd_addr_q = '0;
    logic [27:0] prev_caddr = '0;
    logic [7:0]  cmd_len_q = '0;
    logic [63:0] prev_data = '0;
    bit prev_stall = 1'b0;
    bit prev_cstall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            beats = 0; rd_cnt = 0; prev_stall = 1'b0; prev_cstall = 1'b0;
        end else begin
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                if (bus.fifo_rd_empty) empty_err++;
            end
            if (prev_stall && !(bus.wdata_valid && bus.wdata == prev_data)) stall_err++;
            if (prev_cstall && !(bus.cmd_valid && bus.cmd_addr == prev_caddr)) stall_err++;
            prev_stall  = bus.wdata_valid && !bus.wdata_ready;
            prev_data   = bus.wdata;
            prev_cstall = bus.cmd_valid && !bus.cmd_ready;
            prev_caddr  = bus.cmd_addr;
            if (bus.cmd_valid) cmd_cycles++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_seen++;
                cmd_addr_q = bus.cmd_addr;
                cmd_len_q  = bus.cmd_len;
                beats = 0; rd_cnt = 0; data_err = 0; last_err = 0;
            end
            if (bus.wdata_last != (bus.wdata_valid && beats == 63)) last_err++;
            if (bus.wdata_valid && bus.wdata_ready) begin
                if (exp_q.size() == 0) data_err++;
                else begin
                    if (bus.wdata != exp_q[0]) data_err++;
                    void'(exp_q.pop_front());
                end
                beats++;
            end
        end
    end

    function automatic logic [127:0] outs();
        return 128'({bus.fifo_rd_en, bus.cmd_valid, bus.cmd_addr, bus.cmd_len, bus.wdata_valid,
                     bus.wdata, bus.wdata_last, busy, frame_buf_idx});
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = {32'(pk) ^ 32'hA5A5_0F0F, 32'(pk) + 32'h1000_0000};
            exp_q.push_back(mem[wp]);
            wp++;
            pk++;
        end
    endtask

    task automatic pulse_fs();
        @(posedge clk); #2 frame_start = 1'b1;
        @(posedge clk); #2 frame_start = 1'b0;
    endtask

    typedef struct {
        int          id;
        int          npush;
        int          cmd_wait;
        bit          rnd;
        int          fs_beat;
        logic [27:0] exp_addr;
        logic        exp_idx;
    } vec_t;

    vec_t vecs [8];

    task automatic run_burst(input vec_t v);
        int  n0;
        bit  ok;
        bit  fs_done;
        n0 = cmd_seen;
        @(posedge clk); #2;
        rnd_ready     = v.rnd;
        bus.cmd_ready = (v.cmd_wait == 0);
        push(v.npush);
        if (v.cmd_wait > 0) begin
            repeat (v.cmd_wait) @(negedge clk);
            check($sformatf("b%0d_cmd_held", v.id), {bus.cmd_valid, bus.cmd_addr}, {1'b1, v.exp_addr});
            @(posedge clk); #2 bus.cmd_ready = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_seen != n0) begin ok = 1'b1; break; end
        end
        check($sformatf("b%0d_cmd_timeout", v.id), ok, 1'b1);
        check($sformatf("b%0d_cmd_addr", v.id), cmd_addr_q, v.exp_addr);
        check($sformatf("b%0d_cmd_len", v.id), cmd_len_q, 8'd63);
        ok = 1'b0;
        fs_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (v.fs_beat >= 0 && !fs_done && beats == v.fs_beat) begin
                fs_done = 1'b1;
                pulse_fs();
            end
            if (beats >= 64 && !busy) begin ok = 1'b1; break; end
        end
        check($sformatf("b%0d_done_timeout", v.id), ok, 1'b1);
        check($sformatf("b%0d_beats", v.id), beats, 64);
        check($sformatf("b%0d_fifo_reads", v.id), rd_cnt, 64);
        check($sformatf("b%0d_data_errors", v.id), data_err, 0);
        check($sformatf("b%0d_last_errors", v.id), last_err, 0);
        check($sformatf("b%0d_frame_buf_idx", v.id), frame_buf_idx, v.exp_idx);
    endtask

    initial begin
        vec_t rv;
        bit   ok;
        bus.cmd_ready   = 1'b1;
        bus.wresp_valid = 1'b1;
        bus.wdata_ready = 1'b1;

        //         id npush wait rnd fs   exp_addr                     exp_idx
        vecs[0] = '{0, 1,   0,   0,  -1,  28'h000,                     1'b0};
        vecs[1] = '{1, 64,  3,   1,  -1,  28'h200,                     1'b0};
        vecs[2] = '{2, 64,  0,   0,  10,  28'h400,                     PP};
        vecs[3] = '{3, 64,  0,   0,  -1,  PP ? 28'h800 : 28'h000,      PP};
        vecs[4] = '{4, 64,  0,   1,  -1,  PP ? 28'hA00 : 28'h200,      PP};
        vecs[5] = '{5, 64,  2,   0,  -1,  PP ? 28'hC00 : 28'h400,      PP};
        vecs[6] = '{6, 64,  0,   1,  -1,  PP ? 28'hE00 : 28'h600,      PP};
        vecs[7] = '{7, 64,  0,   0,  -1,  PP ? 28'h800 : 28'h000,      PP};

        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), '0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), '0);

        @(posedge clk); #2 push(63);
        repeat (100) @(negedge clk);
        check("no_cmd_at_level_63", cmd_cycles, 0);

        for (int i = 0; i < 8; i++) run_burst(vecs[i]);

        @(posedge clk); #2;
        push(64);
        frame_start = 1'b1;
        @(posedge clk); #2 frame_start = 1'b0;
        @(negedge clk);
        check("idle_fs_delays_cmd", bus.cmd_valid, 1'b0);
        rv = '{8, 0, 0, 0, -1, 28'h000, 1'b0};
        run_burst(rv);

        @(posedge clk); #2 push(64);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (beats == 30) begin ok = 1'b1; break; end
        end
        check("reach_beat_30", ok, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs(), '0);
        wp = rp;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rv = '{9, 64, 0, 0, -1, 28'h000, 1'b0};
        run_burst(rv);

        check("fifo_read_when_empty", empty_err, 0);
        check("stall_stability", stall_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr_wr_burst_ctrl.md
Name: ddr_wr_burst_ctrl

Overview:
- Sits directly downstream of the 16-to-64-bit async image input FIFO, in the FIFO read-clock domain.
- Watches the FIFO read water level and drains one fixed-length burst of 64-bit words at a time.
- Each burst becomes one write command plus a data beat stream to the DDR write port, with a frame-relative linear address.
- Re-arms the address to the frame base on each frame-start pulse.

Parameters:
- DATA_WIDTH, 64, FIFO read data and DDR write data width.
- ADDR_WIDTH, 28, DDR byte address width.
- LEVEL_WIDTH, 10, width of FIFO read water level input.
- BURST_LEN, 64, beats per burst (power of 2, 2..256).
- FRAME_BASE, 0, byte address of frame buffer 0.
- FRAME_BYTES, 1572864, bytes per frame (1024x768x16bpp); must be a multiple of BURST_LEN*DATA_WIDTH/8.

Ports:
- clk  in  1  FIFO read clock, used for all logic.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse, already synchronous to clk.
- fifo_rd_level  in  LEVEL_WIDTH  FIFO read water level (words).
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_WIDTH  FIFO data, valid the cycle after fifo_rd_en (no output register).
- cmd_valid  out  1  write command valid.
- cmd_ready  in  1  write command accepted.
- cmd_addr  out  ADDR_WIDTH  burst start byte address.
- cmd_len  out  8  BURST_LEN-1.
- wdata_valid  out  1  write beat valid.
- wdata_ready  in  1  write beat accepted.
- wdata  out  DATA_WIDTH  write beat data.
- wdata_last  out  1  final beat of burst.
- wresp_valid  in  1  burst completion response (always accepted).
- busy  out  1  state != IDLE.
- frame_buf_idx  out  1  active frame buffer index (see Optional Feature).

Behaviour:
- Reset (async assert, clk-synchronous release):
  - All outputs are 0.
  - cur_addr = FRAME_BASE.
  - State = IDLE; skid buffer empty; pending_frame = 0.
- Burst byte step: BSTEP = BURST_LEN*DATA_WIDTH/8 (512 at defaults).
- FSM:
  - IDLE -> CMD when fifo_rd_level >= BURST_LEN and pending_frame = 0. Decision is registered: cmd_valid rises the next cycle.
  - CMD:
    - cmd_valid = 1, cmd_addr = cur_addr, both held stable until cmd_valid & cmd_ready.
    - On that handshake -> DATA, beat counter = 0.
  - DATA:
    - Streams exactly BURST_LEN beats; a beat transfers on wdata_valid & wdata_ready.
    - wdata_last = 1 only when beat counter = BURST_LEN-1 and wdata_valid = 1.
    - On the last beat transfer -> RESP.
  - RESP:
    - Waits for wresp_valid, then -> IDLE.
    - Same cycle: cur_addr += BSTEP; if result >= FRAME_BASE + FRAME_BYTES it wraps to FRAME_BASE.
- FIFO read path:
  - 2-entry skid buffer, read latency 1.
  - fifo_rd_en = 1 only in DATA, when !fifo_rd_empty and (buffered + in-flight) < 2 and words requested this burst < BURST_LEN.
  - Never more than BURST_LEN reads per burst; never a read while empty.
  - wdata_valid = skid buffer non-empty. wdata/wdata_valid hold stable while !wdata_ready.
  - Full throughput: 1 beat/clk when wdata_ready stays high.
- frame_start:
  - In IDLE: cur_addr = FRAME_BASE the next cycle.
  - In any other state: sets pending_frame. The current burst completes unmodified; on RESP exit cur_addr = FRAME_BASE instead of incrementing, then pending_frame clears.
  - Two pulses before completion coalesce into one.
- Simultaneous IDLE-entry level condition and frame_start: the address reset has priority, and the burst starts one cycle later at FRAME_BASE.
- wresp_valid outside RESP is ignored.
- Reset mid-burst: immediate abort; no partial-burst recovery is required.

Optional Feature:
- Macro: DDR_WR_PINGPONG_EN.
- Defined:
  - Two buffers at FRAME_BASE and FRAME_BASE + FRAME_BYTES.
  - Each applied frame_start toggles frame_buf_idx, and the base used for reset and wrap becomes FRAME_BASE + frame_buf_idx*FRAME_BYTES.
  - frame_buf_idx resets to 0; the first frame_start after reset selects buffer 1.
- Undefined:
  - Single buffer at FRAME_BASE.
  - frame_buf_idx tied to 0.

Test Plan:
- Level 63 held, wresp tied high -> no cmd_valid for 100 cycles. Level rises to 64 -> cmd_valid with cmd_addr=0x0 and cmd_len=63; 64 beats with wdata matching FIFO order; wdata_last on beat 63; fifo_rd_en asserted exactly 64 times.
- Three back-to-back bursts -> cmd_addr 0x000, 0x200, 0x400.
- Random wdata_ready (50%) -> no lost or duplicated beat, wdata stable while stalled, FIFO never read when empty.
- Preload cur_addr to 0x17FE00 (last burst) -> after completion the next cmd_addr is 0x0.
- frame_start pulse at beat 10 of a burst at 0x400 -> burst completes at 0x400 with 64 beats, next cmd_addr = 0x0. With DDR_WR_PINGPONG_EN defined: next cmd_addr = 0x180000 and frame_buf_idx = 1.
- rst_n low at beat 30 -> all outputs 0 asynchronously. After release, next burst at 0x0 once level >= 64.
